dmem_bus_demux4: RTL and testbench

Single-initiator to four-target bus dispatcher for the data-memory path. It accepts one load/store request from the core's memory stage and routes it to one of four targets selected by a 2-bit target index: RAM, ROM, MMIO, or scratch. It waits for that target's acknowledge, steers the selected target's read data back to the core, and guards each transaction with a timeout. It is the one-to-four, request-fanning counterpart of the core's four-to-one result selection.

---
 rtl/dmem_bus_demux4.sv | 110 +++++++++++
 tb/tb_dmem_bus_demux4.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/dmem_bus_demux4.sv
// Data-memory bus dispatcher: one core request fanned out to RAM/ROM/MMIO/scratch,
// with per-transaction ack wait, read-data steering and a timeout error response.
//
// state | meaning
// IDLE  | m_ready high, waiting for m_req
// BUSY  | one-hot s_req held, waiting for the selected target's ack or timeout
// RESP  | one-cycle m_rvalid strobe, then back to IDLE
module dmem_bus_demux4 #(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [1:0]  m_sel,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ready,
  output logic        m_rvalid,
  output logic [31:0] m_rdata,
  output logic        m_err,
  output logic [3:0]  s_req,
  output logic        s_we,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [3:0]  s_ack,
  input  logic [31:0] s_rdata0,
  input  logic [31:0] s_rdata1,
  input  logic [31:0] s_rdata2,
  input  logic [31:0] s_rdata3
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // A zero TIMEOUT still needs a 1-bit counter so the declaration stays legal.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    state;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt;
  logic          ack_hit;
  logic          timeout_hit;
  logic [31:0]   sel_rdata;

  always_comb begin
    sel_rdata = s_rdata0;
    case (sel_q)
      2'd0:    sel_rdata = s_rdata0;
      2'd1:    sel_rdata = s_rdata1;
      2'd2:    sel_rdata = s_rdata2;
      default: sel_rdata = s_rdata3;
    endcase
  end

  assign ack_hit     = s_ack[sel_q];
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign m_ready     = (state == S_IDLE);
  assign m_rvalid    = (state == S_RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sel_q   <= 2'd0;
      cnt     <= '0;
      s_req   <= 4'd0;
      s_we    <= 1'b0;
      s_addr  <= 32'd0;
      s_wdata <= 32'd0;
      m_rdata <= 32'd0;
      m_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m_req) begin
            sel_q   <= m_sel;
            s_we    <= m_we;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_req   <= 4'b0001 << m_sel;
            cnt     <= '0;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (ack_hit) begin
            m_rdata <= s_we ? 32'd0 : sel_rdata;
            m_err   <= 1'b0;
            s_req   <= 4'd0;
            state   <= S_RESP;
          end else if (timeout_hit) begin
            m_rdata <= ERR_DATA;
            m_err   <= 1'b1;
            s_req   <= 4'd0;
            state   <= S_RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_demux4.sv
// Table-driven bench for dmem_bus_demux4 (TIMEOUT = 4): loads, stores, stray acks,
// timeouts, ack/timeout collision, and reset in the middle of a transaction.
module tb_dmem_bus_demux4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_req, m_we;
  logic [1:0]  m_sel;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready, m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic [3:0]  s_req, s_ack;
  logic        s_we;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata0, s_rdata1, s_rdata2, s_rdata3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_bus_demux4 #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_ack(s_ack),
    .s_rdata0(s_rdata0), .s_rdata1(s_rdata1), .s_rdata2(s_rdata2), .s_rdata3(s_rdata3)
  );

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  stray;
    int          ack_at;
    int          exp_cycles;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    // we sel addr wdata rdata stray ack_at exp_cycles exp_err exp_rdata
    // ack_at counts BUSY cycles from 0; 9 = never acks. TIMEOUT=4 expires in BUSY cycle 3.
    vecs[0] = '{1'b0, 2'd2, 32'h1000_0040, 32'h0,          32'hA5A5_0001, 4'b0000, 3, 4, 1'b0, 32'hA5A5_0001};
    vecs[1] = '{1'b1, 2'd0, 32'h0000_0100, 32'h1234_5678, 32'hFFFF_FFFF, 4'b0000, 0, 1, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 2'd1, 32'h2000_0008, 32'h0,          32'h1111_2222, 4'b1000, 2, 3, 1'b0, 32'h1111_2222};
    vecs[3] = '{1'b0, 2'd3, 32'h3000_0000, 32'h0,          32'h5555_AAAA, 4'b0000, 9, 4, 1'b1, 32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 2'd0, 32'h0000_0004, 32'h0,          32'h0000_CAFE, 4'b0000, 1, 2, 1'b0, 32'h0000_CAFE};
    vecs[5] = '{1'b1, 2'd3, 32'h3000_0010, 32'h0BAD_F00D, 32'h7777_7777, 4'b0000, 3, 4, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 2'd1, 32'h2000_0020, 32'h0,          32'h9999_0000, 4'b0001, 9, 4, 1'b1, 32'hDEAD_BEEF};

    rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_sel = 2'd0; m_addr = '0; m_wdata = '0;
    s_ack = 4'd0; s_rdata0 = '0; s_rdata1 = '0; s_rdata2 = '0; s_rdata3 = '0;
    #1;
    chk("rst_m_ready", m_ready, 1);
    chk("rst_m_rvalid", m_rvalid, 0);
    chk("rst_m_rdata", m_rdata, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_s_req", s_req, 0);
    chk("rst_s_addr", s_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      vec_t v;
      logic [3:0] onehot;
      int n;
      logic got;
      v = vecs[i];
      onehot = 4'b0001 << v.sel;
      s_rdata0 = (v.sel == 2'd0) ? v.rdata : ~v.rdata;
      s_rdata1 = (v.sel == 2'd1) ? v.rdata : ~v.rdata;
      s_rdata2 = (v.sel == 2'd2) ? v.rdata : ~v.rdata;
      s_rdata3 = (v.sel == 2'd3) ? v.rdata : ~v.rdata;

      @(negedge clk);
      chk("idle_ready", m_ready, 1);
      m_req = 1'b1; m_we = v.we; m_sel = v.sel; m_addr = v.addr; m_wdata = v.wdata;
      @(negedge clk);
      m_req = 1'b0; m_addr = 32'hFFFF_FFFF; m_wdata = 32'hFFFF_FFFF; m_we = ~v.we;
      chk("busy_s_req", s_req, onehot);
      chk("busy_s_we", s_we, v.we);
      chk("busy_s_addr", s_addr, v.addr);
      chk("busy_s_wdata", s_wdata, v.wdata);
      chk("busy_ready", m_ready, 0);

      n = 0; got = 1'b0;
      while (!got && n < 12) begin
        s_ack = ((n == 0) ? v.stray : 4'b0000) | ((n == v.ack_at) ? onehot : 4'b0000);
        @(negedge clk);
        s_ack = 4'd0;
        n++;
        if (m_rvalid) got = 1'b1;
        else chk("busy_s_req_held", s_req, onehot);
      end
      chk("resp_cycles", n, v.exp_cycles);
      chk("resp_rdata", m_rdata, v.exp_rdata);
      chk("resp_err", m_err, v.exp_err);
      chk("resp_s_req", s_req, 0);
      chk("resp_ready", m_ready, 0);

      @(negedge clk);
      chk("post_rvalid", m_rvalid, 0);
      chk("post_ready", m_ready, 1);
      chk("post_rdata_hold", m_rdata, v.exp_rdata);
      chk("post_err_hold", m_err, v.exp_err);
    end

    // Reset asserted mid-cycle while BUSY.
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_sel = 2'd2; m_addr = 32'h1000_0080;
    @(negedge clk);
    m_req = 1'b0;
    chk("rst_mid_s_req_before", s_req, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_s_req", s_req, 0);
    chk("rst_mid_ready", m_ready, 1);
    s_ack = 4'b0100;
    @(negedge clk);
    s_ack = 4'd0;
    chk("rst_mid_rvalid", m_rvalid, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_rel_rvalid", m_rvalid, 0);
      chk("rst_rel_ready", m_ready, 1);
      chk("rst_rel_s_req", s_req, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
